// File: rtl/game_sequencer_n_pkg.sv
// Shared definitions for the game sequencer: state encoding, coordinate widths,
// player spawn point and enemy roll helpers (roll_vy only with VERTICAL_DRIFT_EN).
package game_pkg;

    localparam int X_W = 8;
    localparam int Y_W = 7;

    localparam logic [X_W-1:0] PLAYER_X0 = 8'd72;
    localparam logic [Y_W-1:0] PLAYER_Y0 = 7'd52;

    typedef enum logic [3:0] {
        ST_LOAD   = 4'd0,
        ST_START  = 4'd1,
        ST_ERASE  = 4'd2,
        ST_DRAW   = 4'd3,
        ST_DETECT = 4'd4,
        ST_DEAD   = 4'd5,
        ST_IDLE   = 4'd6
    } state_e;

    // Speed is kept as its literal pixel step so the shift path needs no decode.
    function automatic logic [1:0] roll_speed(input logic [1:0] rnd);
        return rnd[1] ? 2'd2 : 2'd1;
    endfunction

`ifdef VERTICAL_DRIFT_EN
    function automatic logic signed [1:0] roll_vy(input logic [1:0] rnd);
        case (rnd)
            2'b00:   return -2'sd1;
            2'b01:   return 2'sd1;
            default: return 2'sd0;
        endcase
    endfunction
`endif

endpackage

// File: rtl/game_sequencer_n_if.sv
// Bundle between the sequencer (master) and the sprite drawer / game environment (slave).
interface game_sequencer_n_if
    import game_pkg::*;
#(
    parameter int NUM_ENEMIES = 2
) ();

    localparam int SEL_W = $clog2(NUM_ENEMIES + 1);

    logic                         blow;
    logic                         update;
    logic                         continue_draw;
    logic [1:0]                   rand_val;
    logic                         draw_done;
    logic [X_W-1:0]               player_x;
    logic [Y_W-1:0]               player_y;
    logic [X_W*NUM_ENEMIES-1:0]   enemy_x;
    logic [Y_W*NUM_ENEMIES-1:0]   enemy_y;

    logic [SEL_W-1:0]             sprite_sel;
    logic                         load;
    logic [X_W-1:0]               load_x;
    logic [Y_W-1:0]               load_y;
    logic                         draw_en;
    logic                         erase;
    logic                         write_en;
    logic signed [2:0]            shift_x;
    logic signed [2:0]            shift_y;
    logic                         dead;
    logic [3:0]                   state;

    modport master (
        input  blow, update, continue_draw, rand_val, draw_done,
               player_x, player_y, enemy_x, enemy_y,
        output sprite_sel, load, load_x, load_y, draw_en, erase, write_en,
               shift_x, shift_y, dead, state
    );

    modport slave (
        output blow, update, continue_draw, rand_val, draw_done,
               player_x, player_y, enemy_x, enemy_y,
        input  sprite_sel, load, load_x, load_y, draw_en, erase, write_en,
               shift_x, shift_y, dead, state
    );

endinterface

// File: rtl/game_sequencer_n_box_overlap.sv
// Axis-aligned overlap test between the player box and one enemy box.
module box_overlap
    import game_pkg::*;
#(
    parameter int SPR_W   = 16,
    parameter int SPR_H   = 16,
    parameter int ENEMY_H = 4
) (
    input  logic [X_W-1:0] px,
    input  logic [Y_W-1:0] py,
    input  logic [X_W-1:0] ex,
    input  logic [Y_W-1:0] ey,
    output logic           hit
);

    // One spare bit keeps edge sums near the right/bottom of the screen from wrapping.
    logic [8:0] px9, py9, ex9, ey9;

    assign px9 = {1'b0, px};
    assign ex9 = {1'b0, ex};
    assign py9 = {2'b00, py};
    assign ey9 = {2'b00, ey};

    assign hit = (ex9 <= px9 + 9'(SPR_W))
              && (ex9 + 9'(SPR_W) >= px9)
              && (ey9 <= py9 + 9'(SPR_H))
              && (ey9 + 9'(ENEMY_H) >= py9);

endmodule

// File: rtl/game_sequencer_n.sv
// Game sequencer: spawns sprites, walks erase/draw passes, scans for collisions.
// Optional VERTICAL_DRIFT_EN gives each enemy a rolled vertical velocity.
module game_sequencer_n
    import game_pkg::*;
#(
    parameter int NUM_ENEMIES = 2,
    parameter int X_MAX       = 180,
    parameter int SPR_W       = 16,
    parameter int SPR_H       = 16,
    parameter int ENEMY_H     = 4
) (
    input  logic               clock,
    input  logic               reset,
    game_sequencer_n_if.master bus
);

    localparam int               SEL_W     = $clog2(NUM_ENEMIES + 1);
    localparam logic [SEL_W-1:0] LAST_SEL  = SEL_W'(NUM_ENEMIES);
    localparam logic [SEL_W-1:0] LAST_SCAN = SEL_W'(NUM_ENEMIES - 1);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] scan_q, scan_d;
    logic             first_pass_q, first_pass_d;
    logic             dead_pulsed_q, dead_pulsed_d;
    logic [1:0]       speed_q [NUM_ENEMIES];
    logic [1:0]       speed_d [NUM_ENEMIES];
`ifdef VERTICAL_DRIFT_EN
    logic signed [1:0] vy_q [NUM_ENEMIES];
    logic signed [1:0] vy_d [NUM_ENEMIES];
`endif

    logic [X_W-1:0]   ex [NUM_ENEMIES];
    logic [Y_W-1:0]   ey [NUM_ENEMIES];
    logic [X_W-1:0]   scan_x;
    logic [Y_W-1:0]   scan_y;
    logic             hit;

    logic             load_o, draw_en_o, erase_o, write_en_o, dead_o;
    logic [X_W-1:0]   load_x_o;
    logic [Y_W-1:0]   load_y_o;
    logic signed [2:0] shift_x_o, shift_y_o;

    always_comb begin
        for (int i = 0; i < NUM_ENEMIES; i++) begin
            ex[i] = bus.enemy_x[X_W*i +: X_W];
            ey[i] = bus.enemy_y[Y_W*i +: Y_W];
        end
    end

    // A single comparator is shared across the scan, one enemy per DETECT cycle.
    always_comb begin
        scan_x = '0;
        scan_y = '0;
        for (int i = 0; i < NUM_ENEMIES; i++) begin
            if (scan_q == SEL_W'(i)) begin
                scan_x = ex[i];
                scan_y = ey[i];
            end
        end
    end

    box_overlap #(
        .SPR_W   (SPR_W),
        .SPR_H   (SPR_H),
        .ENEMY_H (ENEMY_H)
    ) u_overlap (
        .px  (bus.player_x),
        .py  (bus.player_y),
        .ex  (scan_x),
        .ey  (scan_y),
        .hit (hit)
    );

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        scan_d        = scan_q;
        first_pass_d  = first_pass_q;
        dead_pulsed_d = dead_pulsed_q;
        speed_d       = speed_q;
`ifdef VERTICAL_DRIFT_EN
        vy_d          = vy_q;
`endif
        load_o     = 1'b0;
        load_x_o   = '0;
        load_y_o   = '0;
        draw_en_o  = 1'b0;
        erase_o    = 1'b0;
        write_en_o = 1'b0;
        shift_x_o  = '0;
        shift_y_o  = '0;
        dead_o     = 1'b0;

        case (state_q)
            ST_LOAD: begin
                load_o = 1'b1;
                if (sel_q == '0) begin
                    load_x_o = PLAYER_X0;
                    load_y_o = PLAYER_Y0;
                end
                for (int i = 0; i < NUM_ENEMIES; i++) begin
                    if (sel_q == SEL_W'(i + 1)) begin
                        load_x_o = (i % 2 == 0) ? X_W'(0) : X_W'(X_MAX);
                        load_y_o = Y_W'((20 + 40 * i) % 120);
                    end
                end
                if (sel_q == LAST_SEL) begin
                    state_d      = ST_START;
                    sel_d        = '0;
                    first_pass_d = 1'b0;
                end else begin
                    sel_d = sel_q + SEL_W'(1);
                end
            end

            ST_START: begin
                draw_en_o  = 1'b1;
                write_en_o = 1'b1;
                if (bus.blow) begin
                    state_d = ST_ERASE;
                    sel_d   = '0;
                end
            end

            ST_ERASE: begin
                draw_en_o  = 1'b1;
                erase_o    = 1'b1;
                write_en_o = 1'b1;
                if (bus.draw_done) begin
                    if (first_pass_q) begin
                        if (sel_q == LAST_SEL) begin
                            state_d = ST_DETECT;
                            scan_d  = '0;
                        end else begin
                            sel_d = sel_q + SEL_W'(1);
                        end
                    end else begin
                        state_d = ST_DRAW;
                        // Enemies sitting on their far edge get a fresh speed as they are redrawn.
                        for (int i = 0; i < NUM_ENEMIES; i++) begin
                            if (sel_q == SEL_W'(i + 1)) begin
                                if ((i % 2 == 1) ? (ex[i] == '0) : (ex[i] >= X_W'(X_MAX))) begin
                                    speed_d[i] = roll_speed(bus.rand_val);
`ifdef VERTICAL_DRIFT_EN
                                    vy_d[i]    = roll_vy(bus.rand_val);
`endif
                                end
                            end
                        end
                    end
                end
            end

            ST_DRAW: begin
                draw_en_o  = 1'b1;
                write_en_o = 1'b1;
                if (sel_q == '0) begin
                    shift_y_o = bus.blow ? -3'sd1 : 3'sd1;
                end
                for (int i = 0; i < NUM_ENEMIES; i++) begin
                    if (sel_q == SEL_W'(i + 1)) begin
                        shift_x_o = (i % 2 == 1) ? -$signed({1'b0, speed_q[i]})
                                                 :  $signed({1'b0, speed_q[i]});
`ifdef VERTICAL_DRIFT_EN
                        shift_y_o = $signed({vy_q[i][1], vy_q[i]});
`endif
                    end
                end
                if (bus.draw_done) begin
                    if (sel_q == LAST_SEL) begin
                        state_d = ST_DETECT;
                        scan_d  = '0;
                    end else begin
                        state_d = ST_ERASE;
                        sel_d   = sel_q + SEL_W'(1);
                    end
                end
            end

            ST_DETECT: begin
                if (hit) begin
                    state_d       = ST_DEAD;
                    sel_d         = '0;
                    dead_pulsed_d = 1'b0;
                end else if (scan_q == LAST_SCAN) begin
                    state_d = ST_IDLE;
                end else begin
                    scan_d = scan_q + SEL_W'(1);
                end
            end

            ST_DEAD: begin
                dead_o        = 1'b1;
                write_en_o    = 1'b1;
                dead_pulsed_d = 1'b1;
                if (!dead_pulsed_q) begin
                    load_o   = 1'b1;
                    load_x_o = bus.player_x;
                    load_y_o = bus.player_y;
                end
            end

            ST_IDLE: begin
                if (bus.update && bus.continue_draw) begin
                    state_d = ST_ERASE;
                    sel_d   = '0;
                end
            end

            default: begin
                state_d = ST_LOAD;
                sel_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_LOAD;
            sel_q         <= '0;
            scan_q        <= '0;
            first_pass_q  <= 1'b1;
            dead_pulsed_q <= 1'b0;
            for (int i = 0; i < NUM_ENEMIES; i++) begin
                speed_q[i] <= 2'd1;
`ifdef VERTICAL_DRIFT_EN
                vy_q[i]    <= 2'sd0;
`endif
            end
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            scan_q        <= scan_d;
            first_pass_q  <= first_pass_d;
            dead_pulsed_q <= dead_pulsed_d;
            speed_q       <= speed_d;
`ifdef VERTICAL_DRIFT_EN
            vy_q          <= vy_d;
`endif
        end
    end

    // Strobes are held quiet while reset is asserted so an interrupted sprite gets no further writes.
    assign bus.sprite_sel = sel_q;
    assign bus.state      = state_q;
    assign bus.load       = load_o & ~reset;
    assign bus.load_x     = load_x_o;
    assign bus.load_y     = load_y_o;
    assign bus.draw_en    = draw_en_o & ~reset;
    assign bus.erase      = erase_o & ~reset;
    assign bus.write_en   = write_en_o & ~reset;
    assign bus.dead       = dead_o & ~reset;
    assign bus.shift_x    = reset ? 3'sd0 : shift_x_o;
    assign bus.shift_y    = reset ? 3'sd0 : shift_y_o;

endmodule

// File: tb/tb_game_sequencer_n.sv
// Directed bench for game_sequencer_n with three enemies; the vertical-drift
// expectation follows VERTICAL_DRIFT_EN.
module tb_game_sequencer_n;
    import game_pkg::*;

    localparam int N = 3;

`ifdef VERTICAL_DRIFT_EN
    localparam int EXP_VY = -1;
`else
    localparam int EXP_VY = 0;
`endif

    logic clock;
    logic reset;
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   detect_cycles;

    int exp_lx [4] = '{72, 0, 180, 0};
    int exp_ly [4] = '{52, 20, 60, 100};

    game_sequencer_n_if #(.NUM_ENEMIES(N)) bus ();

    game_sequencer_n #(
        .NUM_ENEMIES (N),
        .X_MAX       (180),
        .SPR_W       (16),
        .SPR_H       (16),
        .ENEMY_H     (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_draw_done();
        bus.draw_done = 1'b1;
        step();
        bus.draw_done = 1'b0;
    endtask

    task automatic set_enemy(input int idx, input logic [7:0] x, input logic [6:0] y);
        bus.enemy_x[8*idx +: 8] = x;
        bus.enemy_y[7*idx +: 7] = y;
    endtask

    task automatic check_output(input string tag, input logic signed [31:0] observed,
                                input logic signed [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    initial begin
        reset             = 1'b1;
        bus.blow          = 1'b0;
        bus.update        = 1'b0;
        bus.continue_draw = 1'b0;
        bus.rand_val      = 2'b00;
        bus.draw_done     = 1'b0;
        bus.player_x      = 8'd72;
        bus.player_y      = 7'd52;
        bus.enemy_x       = '0;
        bus.enemy_y       = '0;
        set_enemy(0, 8'd180, 7'd100);
        set_enemy(1, 8'd0,   7'd100);
        set_enemy(2, 8'd89,  7'd52);

        // Reset state
        step();
        step();
        check_output("rst_state",    bus.state,      ST_LOAD);
        check_output("rst_sel",      bus.sprite_sel, 0);
        check_output("rst_load",     bus.load,       0);
        check_output("rst_write_en", bus.write_en,   0);
        check_output("rst_dead",     bus.dead,       0);
        check_output("rst_shift_x",  bus.shift_x,    0);

        // Spawn sequence: player then three enemies, then START
        reset = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            check_output("load_strobe", bus.load,       1);
            check_output("load_sel",    bus.sprite_sel, k);
            check_output("load_x",      bus.load_x,     exp_lx[k]);
            check_output("load_y",      bus.load_y,     exp_ly[k]);
            step();
        end
        check_output("start_state",    bus.state,    ST_START);
        check_output("start_draw_en",  bus.draw_en,  1);
        check_output("start_write_en", bus.write_en, 1);
        check_output("start_erase",    bus.erase,    0);
        step();
        check_output("start_hold", bus.state, ST_START);

        // Frame 1: enemy0 sits at X_MAX and rolls speed 2
        bus.rand_val = 2'b10;
        bus.blow     = 1'b1;
        step();
        bus.blow = 1'b0;
        check_output("erase0_state",    bus.state,      ST_ERASE);
        check_output("erase0_sel",      bus.sprite_sel, 0);
        check_output("erase0_erase",    bus.erase,      1);
        check_output("erase0_write_en", bus.write_en,   1);

        bus.update = 1'b1;
        pulse_draw_done();
        bus.update = 1'b0;
        check_output("draw0_state",   bus.state,      ST_DRAW);
        check_output("draw0_sel",     bus.sprite_sel, 0);
        check_output("draw0_erase",   bus.erase,      0);
        check_output("draw0_shift_x", bus.shift_x,    0);
        check_output("draw0_fall",    bus.shift_y,    1);
        bus.blow = 1'b1;
        #1;
        check_output("draw0_rise", bus.shift_y, -1);
        bus.blow = 1'b0;

        pulse_draw_done();
        check_output("erase1_state", bus.state,      ST_ERASE);
        check_output("erase1_sel",   bus.sprite_sel, 1);
        pulse_draw_done();
        check_output("draw1_state",   bus.state,      ST_DRAW);
        check_output("e0_speed2_f1",  bus.shift_x,    2);
        check_output("e0_shift_y_f1", bus.shift_y,    0);

        bus.rand_val = 2'b00;
        pulse_draw_done();
        pulse_draw_done();
        check_output("draw2_sel",   bus.sprite_sel, 2);
        check_output("e1_shift_x",  bus.shift_x,    -1);
        check_output("e1_vy_f1",    bus.shift_y,    EXP_VY);
        pulse_draw_done();
        pulse_draw_done();
        check_output("draw3_sel",  bus.sprite_sel, 3);
        check_output("e2_shift_x", bus.shift_x,    1);

        // Enemy2 at ex=89 is one pixel past the player's right edge: no hit
        pulse_draw_done();
        check_output("detect_entry", bus.state, ST_DETECT);
        detect_cycles = 0;
        while (bus.state == ST_DETECT && detect_cycles < 20) begin
            step();
            detect_cycles++;
        end
        check_output("detect_cycles", detect_cycles,  N);
        check_output("idle_state",    bus.state,      ST_IDLE);
        check_output("idle_write_en", bus.write_en,   0);
        check_output("idle_dead",     bus.dead,       0);

        bus.update = 1'b1;
        step();
        check_output("idle_gate_hold", bus.state, ST_IDLE);
        bus.continue_draw = 1'b1;
        step();
        bus.update        = 1'b0;
        bus.continue_draw = 1'b0;
        check_output("idle_exit_state", bus.state,      ST_ERASE);
        check_output("idle_exit_sel",   bus.sprite_sel, 0);

        // Frame 2: enemies away from edges keep their rolled speed/velocity
        set_enemy(0, 8'd150, 7'd100);
        set_enemy(1, 8'd40,  7'd100);
        bus.rand_val = 2'b11;
        pulse_draw_done();
        pulse_draw_done();
        pulse_draw_done();
        check_output("f2_draw1_sel",  bus.sprite_sel, 1);
        check_output("e0_speed2_f2",  bus.shift_x,    2);
        pulse_draw_done();
        pulse_draw_done();
        check_output("f2_draw2_state", bus.state,   ST_DRAW);
        check_output("f2_e1_shift_x",  bus.shift_x, -1);
        check_output("e1_vy_f2",       bus.shift_y, EXP_VY);

        // Reset in the middle of enemy1's DRAW
        reset = 1'b1;
        #1;
        check_output("midrst_write_en_now", bus.write_en, 0);
        step();
        check_output("midrst_state",    bus.state,      ST_LOAD);
        check_output("midrst_write_en", bus.write_en,   0);
        check_output("midrst_sel",      bus.sprite_sel, 0);
        reset = 1'b0;
        #1;
        check_output("reload_strobe", bus.load,   1);
        check_output("reload_x",      bus.load_x, 72);
        check_output("reload_y",      bus.load_y, 52);
        step();
        step();
        step();
        step();
        check_output("reload_start", bus.state, ST_START);

        // Frame 3: enemy0 overlaps the player
        set_enemy(0, 8'd60, 7'd60);
        set_enemy(1, 8'd0,  7'd100);
        bus.rand_val = 2'b00;
        bus.blow     = 1'b1;
        step();
        bus.blow = 1'b0;
        check_output("f3_erase", bus.state, ST_ERASE);
        for (int k = 0; k < 7; k++) pulse_draw_done();
        check_output("f3_draw3_sel",   bus.sprite_sel, 3);
        check_output("f3_draw3_state", bus.state,      ST_DRAW);
        pulse_draw_done();
        check_output("f3_detect", bus.state, ST_DETECT);
        step();
        check_output("dead_state",    bus.state,      ST_DEAD);
        check_output("dead_load",     bus.load,       1);
        check_output("dead_load_x",   bus.load_x,     72);
        check_output("dead_load_y",   bus.load_y,     52);
        check_output("dead_flag",     bus.dead,       1);
        check_output("dead_sel",      bus.sprite_sel, 0);
        check_output("dead_write_en", bus.write_en,   1);
        step();
        check_output("dead_load_off",  bus.load,     0);
        check_output("dead_hold_flag", bus.dead,     1);
        check_output("dead_hold_we",   bus.write_en, 1);
        bus.update        = 1'b1;
        bus.continue_draw = 1'b1;
        step();
        check_output("dead_sticky", bus.state, ST_DEAD);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
